fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameters SHALL be:
- N, 32, instruction width.
- RESET_PC, 64'h0, PC value loaded on reset.
- HALT_WORD, 32'hb400001f, instruction word that ends fetching.
REQ-002 The ports SHALL be (name, direction, width, meaning):
- clk, input, 1, sole clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, leave IDLE and begin fetching.
- imem_addr, output, 8, word address to the instruction memory; equals pc[9:2].
- imem_q, input, N, combinational read data for imem_addr.
- branch, input, 1, redirect request, valid for one cycle.
- branch_target, input, 64, new PC when branch=1.
- instr, output, N, instruction at the queue head.
- instr_pc, output, 64, PC of the queue-head instruction.
- instr_valid, output, 1, queue head is valid.
- instr_ready, input, 1, consumer accepts the head.
- halted, output, 1, FSM is in HALT.
- fetch_count, output, 16, number of instructions pushed since reset.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, RUN and HALT.
REQ-004 FSM transitions SHALL be:
- IDLE -> RUN when start=1.
- RUN -> HALT on the cycle a pushed word equals HALT_WORD.
- HALT -> RUN on branch=1.
- IDLE and HALT SHALL ignore start otherwise.
REQ-005 The block SHALL keep a 2-entry FIFO of {pc, word} pairs; instr, instr_pc and instr_valid come from the FIFO head with no combinational path from imem_q.
REQ-006 A pop SHALL occur when instr_valid=1 and instr_ready=1.
REQ-007 A push of {pc, imem_q} SHALL occur in RUN when branch=0 and (occupancy<2 or a pop occurs this cycle).
- On a push, pc SHALL become pc+4.
- When no push occurs, pc SHALL hold.
REQ-008 Simultaneous push and pop SHALL leave occupancy unchanged; push and pop on a full FIFO SHALL be legal.
REQ-009 Steady-state throughput with instr_ready=1 SHALL be one instruction per cycle.
- Latency from the PC update to instr_valid for that PC is 1 cycle when the FIFO is empty.
REQ-010 branch=1, in any state except IDLE, SHALL in the same clock edge:
- flush the FIFO (occupancy 0, instr_valid=0 next cycle);
- load pc with branch_target;
- suppress that cycle's push;
- move to RUN.
REQ-011 branch in IDLE SHALL load pc only; the state SHALL remain IDLE.
REQ-012 Priority SHALL be reset > branch > halt detection > push/pop.
- A pop coinciding with branch is discarded by the flush.
REQ-013 The HALT_WORD instruction SHALL itself be pushed; afterwards no further pushes occur.
- Entries already in the FIFO drain normally while in HALT.
REQ-014 pc SHALL wrap modulo 2^64.
- imem_addr wraps naturally: pc 64'h3fc+4 gives imem_addr 8'h00 with pc 64'h400.
REQ-015 fetch_count SHALL increment by 1 per push and saturate at 16'hffff.
- It SHALL NOT reset on branch.
REQ-016 halted SHALL be 1 exactly while the state is HALT (registered).

Reset
REQ-017 On reset=1 at a rising edge, the block SHALL set:
- state=IDLE, pc=RESET_PC;
- FIFO occupancy=0, instr_valid=0;
- instr=0, instr_pc=0;
- halted=0, fetch_count=0.
REQ-018 Reset SHALL override every other input, including branch and start in the same cycle.
REQ-019 Reset asserted mid-operation SHALL discard queued entries; no instr_valid pulse SHALL appear on the cycle after reset.
REQ-020 During reset, imem_addr SHALL equal RESET_PC[9:2] by the next cycle.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Sequential fetch: reset, start=1, instr_ready=1, imem returns addr-tagged words 32'hA000_0000|addr -> instr_pc 0,4,8,... with matching instr on consecutive cycles; fetch_count=10 after 10 pushes.
- Backpressure: instr_ready=0 for 5 cycles -> occupancy reaches 2, pc stalls at 8, instr holds the pc=0 word; ready=1 -> pcs 0,4,8 delivered in order with none lost or duplicated.
- Branch flush: FIFO full at pcs 0,4; branch=1, target 64'h40 -> next cycle instr_valid=0, imem_addr=8'h10; following cycle instr_pc=64'h40.
- Halt: word at pc 64'h20 is 32'hb400001f -> it is delivered, halted=1, imem_addr frozen at 8'h09; branch to 64'h0 -> halted=0, fetch resumes from 0.
- Wrap: branch to 64'h3fc -> pushes at 64'h3fc then 64'h400 with imem_addr 8'hff then 8'h00.
- Mid-run reset with branch=1 and FIFO full -> next cycle instr_valid=0, pc=0, state IDLE, fetch_count=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks a PC through a word-addressed instruction
// memory into a 2-entry {pc, word} queue, with branch redirect and halt detection.
//
// state  | meaning
// S_IDLE | waiting for start; branch only reloads pc
// S_RUN  | pushing one {pc, word} per cycle while the queue has room
// S_HALT | halt word was pushed; queue drains, no new pushes until branch
module fetch_ctrl #(
  parameter int unsigned    N         = 32,
  parameter logic [63:0]    RESET_PC  = 64'h0,
  parameter logic [N-1:0]   HALT_WORD = 32'hb400001f
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [7:0]    imem_addr,
  input  logic [N-1:0]  imem_q,
  input  logic          branch,
  input  logic [63:0]   branch_target,
  output logic [N-1:0]  instr,
  output logic [63:0]   instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic          halted,
  output logic [15:0]   fetch_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [63:0]  r_pc;
  logic [15:0]  r_fetch_count;
  logic [1:0]   r_count;
  logic [63:0]  r_pc0;
  logic [63:0]  r_pc1;
  logic [N-1:0] r_w0;
  logic [N-1:0] r_w1;
  logic         w_pop;
  logic         w_push;

  always_comb begin
    w_pop       = (r_count != 2'd0) && instr_ready;
    // branch suppresses the push; a pop frees a slot in the same cycle
    w_push      = (r_state == S_RUN) && !branch && ((r_count != 2'd2) || w_pop);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start && !branch) w_state_nxt = S_RUN;
      S_RUN: begin
        if (branch)                               w_state_nxt = S_RUN;
        else if (w_push && (imem_q == HALT_WORD)) w_state_nxt = S_HALT;
      end
      S_HALT: if (branch) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_fetch_count <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (branch)      r_pc <= branch_target;
      else if (w_push) r_pc <= r_pc + 64'd4;
      if (w_push && (r_fetch_count != 16'hffff))
        r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  // Shift-style queue: entry 0 is always the head
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 2'd0;
      r_pc0   <= 64'd0;
      r_pc1   <= 64'd0;
      r_w0    <= '0;
      r_w1    <= '0;
    end else if (branch) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_pc0 <= r_pc;
            r_w0  <= imem_q;
          end else begin
            r_pc1 <= r_pc;
            r_w1  <= imem_q;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_pc0   <= r_pc1;
          r_w0    <= r_w1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_pc0 <= r_pc;
            r_w0  <= imem_q;
          end else begin
            r_pc0 <= r_pc1;
            r_w0  <= r_w1;
            r_pc1 <= r_pc;
            r_w1  <= imem_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr   = r_pc[9:2];
  assign instr       = r_w0;
  assign instr_pc    = r_pc0;
  assign instr_valid = (r_count != 2'd0);
  assign halted      = (r_state == S_HALT);
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a queue-based reference model predicts each
// push; a negedge monitor checks every delivered instruction and status output.
module tb_fetch_ctrl;

  localparam logic [31:0] HALT = 32'hb400001f;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  typedef struct packed {logic [63:0] pc; logic [31:0] w;} ent_t;

  logic        clk = 1'b0;
  logic        reset, start, branch, instr_ready;
  logic [63:0] branch_target;
  logic [7:0]  imem_addr;
  logic [31:0] imem_q, instr;
  logic [63:0] instr_pc;
  logic        instr_valid, halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [256];
  assign imem_q = mem[imem_addr];

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr),
    .imem_q(imem_q), .branch(branch), .branch_target(branch_target),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: modeled queue contents, pc, mode and push count
  ent_t        mq[$];
  ent_t        sb_q[$];
  logic [63:0] mpc;
  int          mst;
  logic [15:0] mcnt;
  bit          mon_en = 1'b0;
  ent_t        me;

  always @(posedge clk) begin
    if (reset) begin
      mpc  = 64'h0;
      mq.delete();
      sb_q.delete();
      mst  = M_IDLE;
      mcnt = 16'd0;
      mon_en = 1'b1;
    end else if (mon_en) begin
      if (branch) begin
        mpc = branch_target;
        if (mst != M_IDLE) begin
          mq.delete();
          sb_q.delete();
          mst = M_RUN;
        end
      end else begin
        if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
        if (mst == M_RUN && mq.size() < 2) begin
          me.pc = mpc;
          me.w  = mem[mpc[9:2]];
          mq.push_back(me);
          sb_q.push_back(me);
          if (mcnt != 16'hffff) mcnt = mcnt + 16'd1;
          if (me.w == HALT) mst = M_HALT;
          mpc = mpc + 64'd4;
        end else if (mst == M_IDLE && start) begin
          mst = M_RUN;
        end
      end
    end
  end

  // Monitor: delivered instructions come off the scoreboard in order
  always @(negedge clk) begin
    ent_t ex;
    if (mon_en) begin
      chk("instr_valid", instr_valid, (mq.size() > 0));
      chk("imem_addr", imem_addr, mpc[9:2]);
      chk("halted", halted, (mst == M_HALT));
      chk("fetch_count", fetch_count, mcnt);
      if (instr_valid && instr_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_delivery actual_pc=%h expected=none", instr_pc);
        end else begin
          ex = sb_q.pop_front();
          chk("deliver_pc", instr_pc, ex.pc);
          chk("deliver_word", instr, ex.w);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; branch = 1'b0; instr_ready = 1'b0;
    branch_target = 64'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
    tick(2);
    reset = 1'b0;
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 64'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_count", fetch_count, 16'd0);
    chk("rst_addr", imem_addr, 8'h00);

    // sequential fetch
    start = 1'b1; instr_ready = 1'b1; tick(1);
    start = 1'b0; tick(10);
    chk("seq_count", fetch_count, 16'd10);
    chk("seq_pc", instr_pc, 64'h24);
    chk("seq_instr", instr, 32'hA000_0009);

    // backpressure
    do_reset();
    start = 1'b1; instr_ready = 1'b0; tick(1);
    start = 1'b0; tick(5);
    chk("bp_valid", instr_valid, 1'b1);
    chk("bp_pc", instr_pc, 64'h0);
    chk("bp_instr", instr, 32'hA000_0000);
    chk("bp_addr", imem_addr, 8'h02);
    instr_ready = 1'b1; tick(1);
    chk("bp_next_pc", instr_pc, 64'h4);
    tick(5);

    // branch flush with full queue
    do_reset();
    start = 1'b1; instr_ready = 1'b0; tick(1);
    start = 1'b0; tick(3);
    chk("br_full_pc", instr_pc, 64'h0);
    branch = 1'b1; branch_target = 64'h40; instr_ready = 1'b1; tick(1);
    branch = 1'b0; instr_ready = 1'b0;
    chk("br_valid", instr_valid, 1'b0);
    chk("br_addr", imem_addr, 8'h10);
    tick(1);
    chk("br_valid2", instr_valid, 1'b1);
    chk("br_pc", instr_pc, 64'h40);

    // halt at pc 0x20
    mem[8] = HALT;
    do_reset();
    start = 1'b1; instr_ready = 1'b1; tick(1);
    start = 1'b0; tick(12);
    chk("halt_halted", halted, 1'b1);
    chk("halt_addr", imem_addr, 8'h09);
    chk("halt_count", fetch_count, 16'd9);
    branch = 1'b1; branch_target = 64'h0; tick(1);
    branch = 1'b0;
    chk("resume_halted", halted, 1'b0);
    chk("resume_addr", imem_addr, 8'h00);
    tick(12);
    chk("halt_again", halted, 1'b1);

    // imem_addr wrap
    branch = 1'b1; branch_target = 64'h3fc; tick(1);
    branch = 1'b0;
    chk("wrap_addr_ff", imem_addr, 8'hff);
    tick(1);
    chk("wrap_addr_00", imem_addr, 8'h00);
    tick(1);
    chk("wrap_pc", instr_pc, 64'h400);

    // reset mid-run with branch and a full queue
    instr_ready = 1'b0; tick(3);
    reset = 1'b1; branch = 1'b1; start = 1'b1; branch_target = 64'h80; tick(1);
    reset = 1'b0; branch = 1'b0; start = 1'b0;
    chk("mrst_valid", instr_valid, 1'b0);
    chk("mrst_addr", imem_addr, 8'h00);
    chk("mrst_halted", halted, 1'b0);
    chk("mrst_count", fetch_count, 16'd0);

    // randomized traffic
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[$urandom_range(0, 255)] = HALT;
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 199) == 0);
      start       = ($urandom_range(0, 3) == 0);
      branch      = ($urandom_range(0, 19) == 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: branch_target = 64'hffff_ffff_ffff_fff8;
        1: branch_target = 64'h3f8;
        default: branch_target = {$urandom, $urandom} & ~64'h3;
      endcase
      tick(1);
    end
    reset = 1'b0; start = 1'b0; branch = 1'b0; instr_ready = 1'b1;
    tick(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
